// File: rtl/blake2_msg_buffer_pkg.sv
// Shared types and geometry for the BLAKE2s message-block buffer.
package blake2_msg_buffer_pkg;
   localparam int          BLOCK_BYTES = 64;
   localparam int          BLOCK_WORDS = 16;
   localparam logic [63:0] T_INC       = 64'd64;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_FULL = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   // Byte counter for the final block: message length plus the key block, if any.
   function automatic logic [63:0] t_final(input logic [63:0] ll, input logic [5:0] kk);
      return ll + ((kk != 6'd0) ? T_INC : 64'd0);
   endfunction
endpackage

// File: rtl/blake2_msg_buffer_if.sv
// Host byte stream plus core block handshake/read port.
interface blake2_msg_buffer_if;
   logic        data_v_i;
   logic [7:0]  data_i;
   logic [5:0]  data_idx_i;
   logic        block_first_i;
   logic        block_last_i;
   logic [5:0]  kk_i;
   logic [63:0] ll_i;
   logic        ready_v_o;
   logic        blk_v_o;
   logic        blk_ready_i;
   logic        blk_done_i;
   logic [3:0]  m_idx_i;
   logic [31:0] m_o;
   logic [63:0] t_o;
   logic        first_o;
   logic        last_o;
   logic        overrun_o;

   modport master (
      output data_v_i, data_i, data_idx_i, block_first_i, block_last_i, kk_i, ll_i,
             blk_ready_i, blk_done_i, m_idx_i,
      input  ready_v_o, blk_v_o, m_o, t_o, first_o, last_o, overrun_o
   );

   modport slave (
      input  data_v_i, data_i, data_idx_i, block_first_i, block_last_i, kk_i, ll_i,
             blk_ready_i, blk_done_i, m_idx_i,
      output ready_v_o, blk_v_o, m_o, t_o, first_o, last_o, overrun_o
   );
endinterface

// File: rtl/blake2_msg_buffer_bytes.sv
// 64 x 8 byte-writable block storage with a little-endian 32-bit word read mux.
module blake2_msg_bytes
   import blake2_msg_buffer_pkg::*;
(
   input  logic        clk,
   input  logic        i_we,
   input  logic [5:0]  i_idx,
   input  logic [7:0]  i_data,
   input  logic [3:0]  i_widx,
   output logic [31:0] o_word
);
   logic [BLOCK_BYTES-1:0][7:0] r_mem;

   // Byte-lane write; storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_idx] <= i_data;
   end

   // Packed slice puts the highest byte lane in the MSBs: little-endian word.
   assign o_word = r_mem[{i_widx, 2'b00} +: 4];
endmodule

// File: rtl/blake2_msg_buffer.sv
// Collects one 64-byte message block, latches its flags and byte counter t,
// and offers it to the BLAKE2s core.
module blake2_msg_buffer
   import blake2_msg_buffer_pkg::*;
(
   input logic                  clk,
   input logic                  nreset,
   blake2_msg_buffer_if.slave   bus
);
   state_t      r_state;
   logic        r_ready;
   logic        r_blk_v;
   logic [63:0] r_t;
   logic        r_first;
   logic        r_last;
   logic        r_ovr;
   logic        w_we;
   logic        w_blk_end;
   logic [31:0] w_word;

   assign w_we      = bus.data_v_i && (r_state == ST_FILL);
   assign w_blk_end = w_we && (bus.data_idx_i == 6'(BLOCK_BYTES - 1));

   blake2_msg_bytes u_bytes (
      .clk    (clk),
      .i_we   (w_we),
      .i_idx  (bus.data_idx_i),
      .i_data (bus.data_i),
      .i_widx (bus.m_idx_i),
      .o_word (w_word)
   );

   // Block FSM with registered ready/valid decodes, t counter and flag latches.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state <= ST_FILL;
         r_ready <= 1'b1;
         r_blk_v <= 1'b0;
         r_t     <= 64'd0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: if (w_blk_end) begin
               r_state <= ST_FULL;
               r_ready <= 1'b0;
               r_blk_v <= 1'b1;
               r_first <= bus.block_first_i;
               r_last  <= bus.block_last_i;
               r_t     <= bus.block_last_i ? t_final(bus.ll_i, bus.kk_i) : r_t + T_INC;
            end
            ST_FULL: if (bus.blk_ready_i) begin
               r_state <= ST_BUSY;
               r_blk_v <= 1'b0;
            end
            ST_BUSY: if (bus.blk_done_i) begin
               r_state <= ST_FILL;
               r_ready <= 1'b1;
               // Next message starts counting from zero.
               if (r_last) r_t <= 64'd0;
            end
            default: begin
               r_state <= ST_FILL;
               r_ready <= 1'b1;
               r_blk_v <= 1'b0;
            end
         endcase
      end
   end

   // Sticky flag for any byte strobed while the buffer cannot accept it.
   always_ff @(posedge clk) begin
      if (!nreset)                                  r_ovr <= 1'b0;
      else if (bus.data_v_i && r_state != ST_FILL)  r_ovr <= 1'b1;
   end

   assign bus.ready_v_o = r_ready;
   assign bus.blk_v_o   = r_blk_v;
   assign bus.m_o       = w_word;
   assign bus.t_o       = r_t;
   assign bus.first_o   = r_first;
   assign bus.last_o    = r_last;
   assign bus.overrun_o = r_ovr;
endmodule

// File: doc/blake2_msg_buffer.md
# blake2_msg_buffer

Message-block buffer sitting directly downstream of the byte-serial host interface and upstream of the BLAKE2s compression core. Collects the 64 bytes of one message block from the interface's indexed byte stream, latches the block's first/last flags, and computes the byte-offset counter t. It then presents the block to the compression core through a valid/ready handshake plus a 32-bit word read port. Only one block is held at a time; the host is back-pressured through `ready_v_o` while a block is pending or being compressed.

## Interface
Parameters: none (BLAKE2s geometry fixed: 64-byte block, 16 x 32-bit words).

- clk  in  1  clock
- nreset  in  1  reset, synchronous, active-low
- data_v_i  in  1  byte strobe from host interface
- data_i  in  8  message byte
- data_idx_i  in  6  byte position within block, 0..63
- block_first_i  in  1  current block is first of message (level)
- block_last_i  in  1  current block is last of message (level)
- kk_i  in  6  key length in bytes (0 = unkeyed)
- ll_i  in  64  total message length in bytes, key block excluded
- ready_v_o  out  1  buffer can accept bytes (high only in FILL)
- blk_v_o  out  1  complete block offered to core
- blk_ready_i  in  1  core accepts offered block
- blk_done_i  in  1  core finished with block, buffer may be reused
- m_idx_i  in  4  word index for read port
- m_o  out  32  word m_idx_i of held block, little-endian
- t_o  out  64  byte counter for this block
- first_o  out  1  latched block_first_i
- last_o  out  1  latched block_last_i
- overrun_o  out  1  sticky: byte strobed while not in FILL

## Operation
- States: FILL, FULL, BUSY.
- FILL: each data_v_i writes data_i into byte lane data_idx_i (later write to same lane overwrites). Write with data_idx_i == 63 completes the block: latch first_o/last_o from the block_*_i inputs that cycle, update t, go FULL.
- Host always sends 64 bytes per block; last block is zero-padded by host. The buffer does not pad.
- t update at block completion: non-last block: t <= t + 64 (mod 2^64). Last block: t <= ll_i + (kk_i != 0 ? 64 : 0). After the last block's BUSY exits, t <= 0 for the next message.
- FULL: blk_v_o = 1, held stable with m/t/first/last until blk_ready_i; on blk_ready_i go BUSY.
- BUSY: contents frozen; core reads words via m_idx_i. blk_done_i -> FILL.
- blk_done_i ignored outside BUSY; blk_ready_i ignored outside FULL.
- data_v_i outside FILL: byte dropped, buffer unchanged, overrun_o set to 1 until reset.
- m_o = {byte[4w+3], byte[4w+2], byte[4w+1], byte[4w]}, w = m_idx_i.
- Reset values: state FILL, ready_v_o 1, blk_v_o 0, t_o 0, first_o 0, last_o 0, overrun_o 0. Byte storage is not reset; m_o is undefined until the first block is written.
- Reset mid-block discards partial data, returns to FILL, t_o = 0.

## Timing
- ready_v_o and blk_v_o are registered state decodes. blk_v_o rises the cycle after the idx-63 byte is accepted, and ready_v_o falls in that same cycle.
- Host interface samples ready_v_o with one cycle of skid. A byte arriving in that cycle sets overrun_o; the host must obey ready.
- blk_ready_i in FULL -> BUSY next cycle, blk_v_o low next cycle.
- blk_done_i in BUSY -> FILL next cycle, ready_v_o high next cycle.
- Minimum block turnaround: 64 byte cycles + 1 (FULL) + 1 (BUSY) + core time.
- m_o is combinational from m_idx_i and storage; valid in FULL and BUSY.
- t_o, first_o, last_o change only at block completion or at reset.

## Structure
- Shared package: state enum (FILL/FULL/BUSY); constants BLOCK_BYTES = 64, BLOCK_WORDS = 16, T_INC = 64.
- One sub-module, blake2_msg_bytes: 64 x 8 write-by-byte storage with a 16 x 32 little-endian word read mux.
- Top holds the FSM, the t counter, the flag latches and overrun.

## Test plan
- Single unkeyed last block: bytes 0x00..0x3F with first = last = 1, ll = 3, kk = 0 -> blk_v_o the cycle after idx 63; m_o[0] = 0x03020100, m_o[15] = 0x3F3E3D3C; t_o = 3; first_o = last_o = 1.
- Three-block message, kk = 0, ll = 150 -> t_o = 64, 128, 150. first_o is 1 only on block 0, last_o is 1 only on block 2. After the final blk_done_i, the next block reports t_o = 64.
- Keyed message, kk = 16, ll = 0: key block sent with first = last = 1 -> t_o = 64.
- Back-pressure: hold blk_ready_i low 10 cycles -> blk_v_o and m_o stay stable, ready_v_o stays 0. Strobe a byte in FULL -> overrun_o = 1, m_o unchanged.
- Assert blk_done_i in FILL and FULL -> no state change; blk_done_i in BUSY -> ready_v_o = 1 next cycle.
- Reset after 30 bytes -> state FILL, t_o = 0. A fresh 64-byte block then completes normally with t_o = 64 (non-last).
